ram_dp: RTL
===========

RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter N_WORDS, default 16: memory depth in words, at least 2.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1: read latency in cycles, 1 or 2.
REQ-004 The block SHALL have parameter RDW_MODE, default WRITE_FIRST: same-address read-during-write policy, WRITE_FIRST or READ_FIRST.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write request.
- wr_address  in  $clog2(N_WORDS)  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i selects wr_data[8i+7:8i].
- re  in  1  read request.
- rd_address  in  $clog2(N_WORDS)  read word address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  one-cycle pulse marking rd_data as a new read result.
- init_busy  out  1  high while memory clear runs; requests are ignored.

Function
REQ-006 The block SHALL be a simple dual-port memory: one write and one read accepted per cycle, independently.
REQ-007 The block SHALL use a two-state FSM: INIT and READY.
REQ-008 In INIT the block SHALL write zero to address 0..N_WORDS-1, one word per cycle, then move to READY; init_busy SHALL be high exactly N_WORDS cycles.
REQ-009 In INIT, we and re SHALL be ignored: no memory update and no rd_valid.
REQ-010 A write in READY SHALL update only the bytes whose wr_be bit is 1; wr_be of all zeros SHALL leave memory unchanged.
REQ-011 A read in READY SHALL produce rd_data with rd_valid high exactly RD_LATENCY cycles after the request edge; back-to-back reads SHALL give back-to-back results in request order.
REQ-012 rd_data SHALL hold its last value while rd_valid is low; it SHALL never be driven to z.
REQ-013 When read and write target the same address in the same cycle, rd_data SHALL be the merged new word under WRITE_FIRST, or the pre-write word under READ_FIRST.
REQ-014 When N_WORDS is not a power of two, an out-of-range write SHALL be discarded; an out-of-range read SHALL return zero with rd_valid.
REQ-015 Writes SHALL have no effect on rd_valid timing; simultaneous we and re SHALL both be serviced.

Reset
REQ-016 Asserting rst_n low SHALL immediately force rd_data=0, rd_valid=0, init_busy=1, pipeline valid bits=0 and FSM=INIT with clear address 0.
REQ-017 Reset mid-operation SHALL abort in-flight reads (no rd_valid after release); memory contents are not reset asynchronously and are cleared by INIT after release.
REQ-018 INIT SHALL begin on the first rising edge after rst_n goes high.

Structure
REQ-019 The shared package ram_pkg SHALL hold the rdw_mode_e enum (WRITE_FIRST, READ_FIRST) and the ram_state_e enum (INIT, READY).
REQ-020 The clear sequencer SHALL be a sub-module ram_init_fsm (outputs: clear address, clear enable, init_busy); the array, byte merge, collision logic and read pipeline SHALL stay in ram_dp.
REQ-021 The memory array SHALL be inferable as block RAM; parameter legality SHALL be checked at elaboration.

Verification
REQ-022 Reset/init: release rst_n -> init_busy high 16 cycles, then a read of each address 0..15 returns 0x00000000.
REQ-023 Byte enables: write 0xAABBCCDD with wr_be=1111 to addr 3, then 0x11223344 with wr_be=0101 -> read addr 3 returns 0xAA22CC44.
REQ-024 Collision: addr 5 holds 0x1, then same-cycle write 0x2 and read of addr 5 -> rd_data 0x2 (WRITE_FIRST) or 0x1 (READ_FIRST).
REQ-025 Latency: RD_LATENCY=2, reads of addr 0..3 on cycles N..N+3 -> rd_valid on cycles N+2..N+5 with data in order.
REQ-026 Ignore and abort: we to addr 2 with 0xFF during init_busy -> addr 2 reads 0; rst_n low one cycle after a read -> rd_valid stays 0, rd_data=0, init restarts.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg -- shared types for the dual-port RAM slice.
//   rdw_mode_e  : same-address read-during-write policy
//   ram_state_e : clear sequencer states
package ram_pkg;

    typedef enum logic {
        WRITE_FIRST = 1'b0,
        READ_FIRST  = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_init_fsm.sv
// ram_init_fsm -- clears the memory after reset, one word per cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_addr  : word address being cleared this cycle
//   clear_en    : write zero to clear_addr on this rising edge
//   init_busy   : high while the clear runs (exactly N_WORDS cycles)
//   state       : current FSM state, exposed for debug / checkers
module ram_init_fsm
    import ram_pkg::*;
#(
    parameter int N_WORDS = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] clear_addr,
    output logic          clear_en,
    output logic          init_busy,
    output ram_state_e    state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);

    ram_state_e    next_state;
    logic [AW-1:0] next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            clear_addr <= '0;
        end else begin
            state      <= next_state;
            clear_addr <= next_addr;
        end
    end

    always_comb begin
        next_state = state;
        next_addr  = clear_addr;
        clear_en   = 1'b0;
        init_busy  = 1'b0;
        case (state)
            INIT: begin
                clear_en  = 1'b1;
                init_busy = 1'b1;
                if (clear_addr == LAST_ADDR) begin
                    next_state = READY;
                    next_addr  = '0;
                end else begin
                    next_addr = clear_addr + 1'b1;
                end
            end
            READY: begin
                next_state = READY;
            end
            default: begin
                next_state = INIT;
                next_addr  = '0;
            end
        endcase
    end

endmodule

// File: rtl/ram_dp.sv
// ram_dp -- simple dual-port RAM with byte enables, post-reset clear,
// configurable read latency (1 or 2) and read-during-write policy.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   we, wr_address,
//   wr_data, wr_be       : write port; wr_be[i] selects wr_data[8i+7:8i]
//   re, rd_address       : read request
//   rd_data, rd_valid    : read result, valid for one cycle RD_LATENCY
//                          cycles after the request edge; rd_data holds
//                          its last value while rd_valid is low
//   init_busy            : memory clear in progress, requests ignored
// Handshake: no backpressure. A request is taken on any rising edge where
// its enable is high and init_busy is low; the read result is presented
// with a one-cycle rd_valid pulse and must be consumed then.
module ram_dp
    import ram_pkg::*;
#(
    parameter int        DATA_WIDTH = 32,
    parameter int        N_WORDS    = 16,
    parameter int        RD_LATENCY = 1,
    parameter rdw_mode_e RDW_MODE   = WRITE_FIRST
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(N_WORDS)-1:0]   wr_address,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic                         re,
    input  logic [$clog2(N_WORDS)-1:0]   rd_address,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         init_busy
);

    localparam int            AW    = $clog2(N_WORDS);
    localparam int            NB    = DATA_WIDTH / 8;
    localparam logic [AW:0]   DEPTH = (AW + 1)'(N_WORDS);

    // Elaboration-time parameter legality.
    if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("ram_dp: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (N_WORDS < 2) begin : g_bad_depth
        $error("ram_dp: N_WORDS must be at least 2");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp: RD_LATENCY must be 1 or 2");
    end

    // Clear sequencer
    logic [AW-1:0] clear_addr;
    logic          clear_en;
    ram_state_e    fsm_state;

    ram_init_fsm #(
        .N_WORDS (N_WORDS),
        .AW      (AW)
    ) u_init (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_addr (clear_addr),
        .clear_en   (clear_en),
        .init_busy  (init_busy),
        .state      (fsm_state)
    );

    logic accept;
    logic wr_in_range, rd_in_range;
    logic wr_fire, rd_fire, wr_hit;

    assign accept      = (fsm_state == READY);
    // Only matters for non-power-of-two depths; otherwise always true.
    assign wr_in_range = ({1'b0, wr_address} < DEPTH);
    assign rd_in_range = ({1'b0, rd_address} < DEPTH);
    assign wr_fire     = we && accept && wr_in_range;
    assign rd_fire     = re && accept;
    assign wr_hit      = wr_fire && (wr_address == rd_address);

    // Memory array: single write port shared by the clear sequencer and
    // the user write port, per-byte write enables.
    logic [DATA_WIDTH-1:0] mem [N_WORDS];
    logic [NB-1:0]         mem_be;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_be    = '0;
        mem_addr  = wr_address;
        mem_wdata = wr_data;
        if (clear_en) begin
            mem_be    = '1;
            mem_addr  = clear_addr;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_be = wr_be;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) begin
                mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Read word with same-address collision handling. Under WRITE_FIRST
    // the enabled bytes of the incoming write replace the stored bytes.
    logic [DATA_WIDTH-1:0] rd_old, rd_word;

    assign rd_old = rd_in_range ? mem[rd_address] : '0;

    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == WRITE_FIRST && wr_hit) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    rd_word[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline. The word is captured on the request edge, so later
    // writes never disturb a result already in flight.
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= rd_fire;
                if (rd_fire) data_q <= rd_word;
            end
        end
    end else begin : g_lat2
        logic                  p1_valid;
        logic [DATA_WIDTH-1:0] p1_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p1_valid <= 1'b0;
                p1_data  <= '0;
                valid_q  <= 1'b0;
                data_q   <= '0;
            end else begin
                p1_valid <= rd_fire;
                if (rd_fire) p1_data <= rd_word;
                valid_q <= p1_valid;
                if (p1_valid) data_q <= p1_data;
            end
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;

endmodule
